// File: rtl/cdma_wt_rsp_tracker.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------------+
// | cdma_wt_rsp_tracker: tags CDMA weight read-response beats with end-of-request |
// | Rev 1.0                                                                      |
// +------------------------------------------------------------------------------+
module cdma_wt_rsp_tracker #(
  parameter int DW    = 512,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             fifo_rd_req,
  output logic             fifo_rd_ready,
  input  logic [5:0]       fifo_rd_data,
  input  logic             dma_rsp_valid,
  output logic             dma_rsp_ready,
  input  logic [DW-1:0]    dma_rsp_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] req_done_cnt,
  output logic             idle
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t     state;
  logic [5:0] beat_rem;
  logic       adv;
  logic       accept;
  logic       last_beat;
  logic       pop;

  assign adv           = !out_valid || out_ready;
  assign dma_rsp_ready = (state == ACTIVE) && adv;
  assign accept        = dma_rsp_valid && dma_rsp_ready;
  assign last_beat     = (beat_rem == 6'd0);

  // Pop in IDLE, or while the last beat of the current request is taken so the
  // next request starts without a bubble; never a function of fifo_rd_req.
  assign fifo_rd_ready = reset_ && ((state == IDLE) || (accept && last_beat));
  assign pop           = fifo_rd_req && fifo_rd_ready;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state        <= IDLE;
      beat_rem     <= 6'd0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      req_done_cnt <= '0;
    end else begin
      if (state == IDLE) begin
        if (pop) begin
          beat_rem <= fifo_rd_data;
          state    <= ACTIVE;
        end
      end else if (accept) begin
        if (!last_beat) begin
          beat_rem <= beat_rem - 6'd1;
        end else if (pop) begin
          beat_rem <= fifo_rd_data;
        end else begin
          state <= IDLE;
        end
      end

      if (accept) begin
        out_valid <= 1'b1;
        out_last  <= last_beat;
        if (last_beat) begin
          req_done_cnt <= req_done_cnt + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Payload needs no reset; it is only meaningful while out_valid is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      out_data <= dma_rsp_data;
    end
  end

  assign idle = (state == IDLE) && !out_valid;

endmodule
`default_nettype wire

// File: tb/tb_cdma_wt_rsp_tracker.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------------+
// | tb_cdma_wt_rsp_tracker: scoreboard bench for cdma_wt_rsp_tracker             |
// | Rev 1.0                                                                      |
// +------------------------------------------------------------------------------+
module tb_cdma_wt_rsp_tracker;
  localparam int DW    = 512;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset_ = 1'b0;
  logic             fifo_rd_req;
  logic             fifo_rd_ready;
  logic [5:0]       fifo_rd_data;
  logic             dma_rsp_valid = 1'b0;
  logic             dma_rsp_ready;
  logic [DW-1:0]    dma_rsp_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [DW-1:0]    out_data;
  logic             out_last;
  logic [CNT_W-1:0] req_done_cnt;
  logic             idle;

  cdma_wt_rsp_tracker #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset_        (reset_),
    .fifo_rd_req   (fifo_rd_req),
    .fifo_rd_ready (fifo_rd_ready),
    .fifo_rd_data  (fifo_rd_data),
    .dma_rsp_valid (dma_rsp_valid),
    .dma_rsp_ready (dma_rsp_ready),
    .dma_rsp_data  (dma_rsp_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .req_done_cnt  (req_done_cnt),
    .idle          (idle)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Tracking FIFO model: stimulus writes, a FIFO-side process pops on handshake.
  logic [5:0] fmem [0:127];
  int wr = 0;
  int rd = 0;
  int pops = 0;
  assign fifo_rd_req  = (wr != rd);
  assign fifo_rd_data = fmem[rd[6:0]];

  always @(posedge clk) begin
    if (reset_ && fifo_rd_req && fifo_rd_ready) begin
      rd   <= rd + 1;
      pops <= pops + 1;
    end
  end

  logic tgl = 1'b0;
  always @(posedge clk) begin
    if (tgl) begin
      #1 out_ready = ~out_ready;
    end
  end

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t       sb[$];
  int          model_q[$];
  int          model_rem = 0;
  logic [15:0] exp_cnt = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_data(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", nm, act[63:0], exp[63:0]);
    end
  endtask

  function automatic logic [DW-1:0] mkdata(input int k);
    logic [DW-1:0] r;
    for (int j = 0; j < 16; j++) begin
      r[j*32 +: 32] = 32'(k * 32'h9E3779B1) ^ 32'(j << 8) ^ 32'h5A5A0000;
    end
    return r;
  endfunction

  task automatic push_entry(input int e);
    fmem[wr[6:0]] = e[5:0];
    wr++;
    model_q.push_back(e + 1);
  endtask

  // Records an accepted beat: expected last comes from the entry list, not the DUT.
  task automatic note_accept(input logic [DW-1:0] d);
    beat_t b;
    if (model_rem == 0) begin
      if (model_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL accept_without_entry: actual=1 required=0");
        return;
      end
      model_rem = model_q.pop_front();
    end
    b.d = d;
    b.l = (model_rem == 1);
    model_rem--;
    if (b.l) exp_cnt = exp_cnt + 16'd1;
    sb.push_back(b);
  endtask

  // Call at posedge+1; returns at posedge+1 after the last beat is accepted.
  task automatic send_beats(input int n, input int base, input int refill, output int stalls);
    int wait_cnt;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      dma_rsp_valid = 1'b1;
      dma_rsp_data  = mkdata(base + i);
      wait_cnt = 0;
      @(negedge clk);
      while (!dma_rsp_ready) begin
        stalls++;
        wait_cnt++;
        if (wait_cnt > 200) begin
          chk("accept_timeout", 64'(wait_cnt), 64'd0);
          dma_rsp_valid = 1'b0;
          return;
        end
        @(negedge clk);
      end
      note_accept(dma_rsp_data);
      @(posedge clk);
      #1;
      if (refill > 0) begin
        push_entry(0);
        refill--;
      end
    end
    dma_rsp_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (reset_) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: actual=1 required=0");
        end else begin
          chk_data("out_data", out_data, sb[0].d);
          chk("out_last", 64'(out_last), 64'(sb[0].l));
          if (out_ready) void'(sb.pop_front());
        end
        if (!out_ready) chk("rsp_ready_stalled", 64'(dma_rsp_ready), 64'd0);
      end
    end
  end

  task automatic chk_reset_vals();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_cnt", 64'(req_done_cnt), 64'd0);
    chk("rst_fifo_ready", 64'(fifo_rd_ready), 64'd0);
    chk("rst_rsp_ready", 64'(dma_rsp_ready), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
  endtask

  initial begin
    int st;
    int pops0;
    for (int i = 0; i < 128; i++) fmem[i] = 6'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk);
    #1 reset_ = 1'b1;
    @(negedge clk);
    chk("idle_fifo_ready", 64'(fifo_rd_ready), 64'd1);

    // Single one-beat request.
    @(posedge clk); #1;
    push_entry(0);
    @(posedge clk); #1;
    send_beats(1, 100, 0, st);
    @(negedge clk);
    chk("t1_out_valid", 64'(out_valid), 64'd1);
    chk("t1_cnt", 64'(req_done_cnt), 64'd1);
    drain();
    chk("t1_idle", 64'(idle), 64'd1);

    // Two preloaded entries, back-to-back across the boundary.
    @(posedge clk); #1;
    pops0 = pops;
    push_entry(3);
    push_entry(1);
    @(posedge clk); #1;
    send_beats(6, 200, 0, st);
    chk("t2_stalls", 64'(st), 64'd0);
    drain();
    chk("t2_pops", 64'(pops - pops0), 64'd2);
    chk("t2_cnt", 64'(req_done_cnt), 64'd3);

    // 64-beat request with toggling backpressure.
    @(posedge clk); #1;
    push_entry(63);
    @(posedge clk); #1;
    tgl = 1'b1;
    send_beats(64, 300, 0, st);
    drain();
    tgl = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    chk("t3_cnt", 64'(req_done_cnt), 64'(exp_cnt));

    // Response with no entry, then entry arrives.
    @(posedge clk); #1;
    dma_rsp_valid = 1'b1;
    dma_rsp_data  = mkdata(400);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_no_entry_ready", 64'(dma_rsp_ready), 64'd0);
    end
    @(posedge clk); #1;
    push_entry(0);
    @(negedge clk);
    chk("t4_pop_cycle_ready", 64'(dma_rsp_ready), 64'd0);
    @(negedge clk);
    chk("t4_active_ready", 64'(dma_rsp_ready), 64'd1);
    note_accept(dma_rsp_data);
    @(posedge clk); #1;
    dma_rsp_valid = 1'b0;
    drain();
    chk("t4_cnt", 64'(req_done_cnt), 64'd5);

    // Reset mid-request with a beat in the out stage.
    @(posedge clk); #1;
    push_entry(7);
    @(posedge clk); #1;
    send_beats(2, 500, 0, st);
    reset_ = 1'b0;
    wr = rd;
    sb.delete();
    model_q.delete();
    model_rem = 0;
    exp_cnt = '0;
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk); #1;
    reset_ = 1'b1;

    // Counter wrap.
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) push_entry(0);
    @(posedge clk); #1;
    send_beats(65535, 1000, 65535 - 64, st);
    drain();
    chk("t6_cnt_max", 64'(req_done_cnt), 64'hFFFF);
    @(posedge clk); #1;
    push_entry(0);
    @(posedge clk); #1;
    send_beats(1, 700, 0, st);
    drain();
    chk("t6_cnt_wrap", 64'(req_done_cnt), 64'd0);
    chk("t6_model_cnt", 64'(req_done_cnt), 64'(exp_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
